// File: rtl/qdec_pkg.sv
// Shared types for the quadrature front end: Gray-coded phase encoding,
// controller states and the forward-step helper used by the decoder.
package qdec_pkg;

    typedef enum logic [1:0] {
        PH0 = 2'b00,
        PH1 = 2'b01,
        PH2 = 2'b11,
        PH3 = 2'b10
    } phase_t;

    typedef enum logic {
        PRIME = 1'b0,
        TRACK = 1'b1
    } qdec_state_t;

    localparam int ERR_CNT_W = 8;

    // Phase that follows ph when the encoder moves one step forward.
    function automatic phase_t phase_fwd(input phase_t ph);
        case (ph)
            PH0:     return PH1;
            PH1:     return PH2;
            PH2:     return PH3;
            default: return PH0;
        endcase
    endfunction

endpackage

// File: rtl/qdec_filter.sv
// One quadrature channel: multi-stage synchroniser followed by a glitch filter
// that only accepts a level held for FILT_LEN consecutive synchronised cycles.
module qdec_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic d_async,
    output logic d_filt
);

    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   d_sync;

    assign d_sync = sync_q[SYNC_STAGES-1];
    assign d_filt = filt_q;

    // While load is high the filter is bypassed so the decoder can prime itself
    // from whatever level the channel currently sits at.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (load) begin
            filt_d = d_sync;
        end else if (d_sync != filt_q) begin
            if (cnt_q == CNT_TC) begin
                filt_d = d_sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

endmodule

// File: rtl/qdec_inc_dec.sv
// Quadrature decoder: filters qa/qb, then turns Gray-code phase steps into
// single-cycle inc/dec pulses and flags/counts illegal double-bit jumps.
module qdec_inc_dec
    import qdec_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter bit DIR_INV     = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 qa,
    input  logic                 qb,
    input  logic                 en,
    output logic                 inc,
    output logic                 dec,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [1:0]           phase
);

    localparam int PRIME_LEN = SYNC_STAGES + FILT_LEN;
    localparam int TMR_W     = $clog2(PRIME_LEN);
    localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(PRIME_LEN - 1);

    logic                 a_filt, b_filt, load;
    phase_t               cur_ph, prev_q, prev_d;
    qdec_state_t          state_q, state_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic                 inc_q, inc_d, dec_q, dec_d, err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 fwd, rev;

    assign load = (state_q == PRIME);

    qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
        .clk(clk), .rst(rst), .load(load), .d_async(qa), .d_filt(a_filt)
    );

    qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
        .clk(clk), .rst(rst), .load(load), .d_async(qb), .d_filt(b_filt)
    );

    assign cur_ph = phase_t'({a_filt, b_filt});

    // The previous phase follows the filtered phase in every state, so PRIME
    // and en=0 both leave the decoder aligned with no pending step.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        prev_d    = cur_ph;
        inc_d     = 1'b0;
        dec_d     = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        fwd       = (cur_ph == phase_fwd(prev_q));
        rev       = (prev_q == phase_fwd(cur_ph));
        case (state_q)
            PRIME: begin
                if (tmr_q == '0) begin
                    state_d = TRACK;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                if (en) begin
                    if ((cur_ph ^ prev_q) == 2'b11) begin
                        err_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end else begin
                        inc_d = DIR_INV ? rev : fwd;
                        dec_d = DIR_INV ? fwd : rev;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PRIME;
            tmr_q     <= TMR_INIT;
            prev_q    <= PH0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            prev_q    <= prev_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign inc     = inc_q;
    assign dec     = dec_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign phase   = cur_ph;

endmodule

// File: tb/tb_qdec_inc_dec.sv
// Directed bench for qdec_inc_dec: a normal and a direction-inverted instance
// share the same quadrature stimulus.
module tb_qdec_inc_dec;

    localparam int SYNC_STAGES = 2;
    localparam int FILT_LEN    = 4;
    localparam int LAT         = SYNC_STAGES + FILT_LEN;

    logic       clk = 1'b0;
    logic       rst, qa, qb, en;
    logic       inc, dec, err;
    logic [7:0] err_cnt;
    logic [1:0] phase;
    logic       inc_v, dec_v, err_v;
    logic [7:0] err_cnt_v;
    logic [1:0] phase_v;

    int checks = 0;
    int errors = 0;

    // Pulse tallies, sampled at posedge so they see the previous cycle's outputs.
    int n_inc = 0, n_dec = 0, n_err = 0;
    int n_inc_v = 0, n_dec_v = 0, n_err_v = 0;
    int n_overlap = 0;

    always #5 clk = ~clk;

    qdec_inc_dec #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .DIR_INV(1'b0)) dut (
        .clk(clk), .rst(rst), .qa(qa), .qb(qb), .en(en),
        .inc(inc), .dec(dec), .err(err), .err_cnt(err_cnt), .phase(phase)
    );

    qdec_inc_dec #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .DIR_INV(1'b1)) dut_inv (
        .clk(clk), .rst(rst), .qa(qa), .qb(qb), .en(en),
        .inc(inc_v), .dec(dec_v), .err(err_v), .err_cnt(err_cnt_v), .phase(phase_v)
    );

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            if (inc === 1'b1)   n_inc++;
            if (dec === 1'b1)   n_dec++;
            if (err === 1'b1)   n_err++;
            if (inc_v === 1'b1) n_inc_v++;
            if (dec_v === 1'b1) n_dec_v++;
            if (err_v === 1'b1) n_err_v++;
            if ((inc === 1'b1 && dec === 1'b1) || (inc_v === 1'b1 && dec_v === 1'b1))
                n_overlap++;
        end
    end

    task automatic step(input logic a, input logic b, input int hold);
        @(negedge clk);
        qa = a;
        qb = b;
        repeat (hold) @(negedge clk);
    endtask

    task automatic test_reset;
        int s_inc, s_dec, s_err;
        rst = 1'b1; qa = 1'b0; qb = 1'b0; en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({inc, dec, err} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b expected 000", {inc, dec, err});
        end
        checks++;
        if (err_cnt !== 8'd0 || phase !== 2'b00) begin
            errors++; $display("FAIL reset_cnt_phase: got err_cnt=%0d phase=%b expected 0/00", err_cnt, phase);
        end
        rst = 1'b0;
        s_inc = n_inc; s_dec = n_dec; s_err = n_err;
        repeat (50) @(negedge clk);
        checks++;
        if ((n_inc - s_inc) !== 0 || (n_dec - s_dec) !== 0 || (n_err - s_err) !== 0) begin
            errors++; $display("FAIL idle_pulses: got inc=%0d dec=%0d err=%0d expected 0/0/0",
                               n_inc - s_inc, n_dec - s_dec, n_err - s_err);
        end
        checks++;
        if (err_cnt !== 8'd0 || phase !== 2'b00) begin
            errors++; $display("FAIL idle_state: got err_cnt=%0d phase=%b expected 0/00", err_cnt, phase);
        end
    endtask

    task automatic test_forward;
        logic [1:0] seq [4];
        int s_inc, s_dec, s_err, s_inc_v, s_dec_v;
        int first, hi;
        seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        s_inc = n_inc; s_dec = n_dec; s_err = n_err; s_inc_v = n_inc_v; s_dec_v = n_dec_v;
        first = -1; hi = 0;
        @(negedge clk);
        qb = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (inc === 1'b1) begin
                hi++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (first !== LAT + 1 || hi !== 1) begin
            errors++; $display("FAIL fwd_latency: got first=%0d width=%0d expected %0d/1", first, hi, LAT + 1);
        end
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                if (r != 0 || j != 0) step(seq[j][1], seq[j][0], 10);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if ((n_inc - s_inc) !== 16 || (n_dec - s_dec) !== 0 || (n_err - s_err) !== 0) begin
            errors++; $display("FAIL fwd_counts: got inc=%0d dec=%0d err=%0d expected 16/0/0",
                               n_inc - s_inc, n_dec - s_dec, n_err - s_err);
        end
        checks++;
        if (((n_inc - s_inc) - (n_dec - s_dec)) !== 16 || phase !== 2'b00) begin
            errors++; $display("FAIL fwd_cnt_phase: got cnt=%0d phase=%b expected 16/00",
                               (n_inc - s_inc) - (n_dec - s_dec), phase);
        end
        checks++;
        if ((n_dec_v - s_dec_v) !== 16 || (n_inc_v - s_inc_v) !== 0) begin
            errors++; $display("FAIL fwd_dir_inv: got inc=%0d dec=%0d expected 0/16",
                               n_inc_v - s_inc_v, n_dec_v - s_dec_v);
        end
    endtask

    task automatic test_reverse;
        int s_inc, s_dec, s_err, s_inc_v;
        s_inc = n_inc; s_dec = n_dec; s_err = n_err; s_inc_v = n_inc_v;
        step(1'b1, 1'b0, 10);
        step(1'b1, 1'b1, 10);
        step(1'b0, 1'b1, 10);
        checks++;
        if ((n_dec - s_dec) !== 3 || (n_inc - s_inc) !== 0 || (n_err - s_err) !== 0) begin
            errors++; $display("FAIL rev_counts: got inc=%0d dec=%0d err=%0d expected 0/3/0",
                               n_inc - s_inc, n_dec - s_dec, n_err - s_err);
        end
        checks++;
        if (phase !== 2'b01 || (n_inc_v - s_inc_v) !== 3) begin
            errors++; $display("FAIL rev_phase_inv: got phase=%b inv_inc=%0d expected 01/3", phase, n_inc_v - s_inc_v);
        end
    endtask

    task automatic test_glitch;
        int s_inc, s_dec, s_err;
        s_inc = n_inc; s_dec = n_dec; s_err = n_err;
        @(negedge clk);
        qa = 1'b1;
        repeat (FILT_LEN - 1) @(negedge clk);
        qa = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if ((n_inc - s_inc) !== 0 || (n_dec - s_dec) !== 0 || (n_err - s_err) !== 0 || phase !== 2'b01) begin
            errors++; $display("FAIL glitch_short: got inc=%0d dec=%0d err=%0d phase=%b expected 0/0/0/01",
                               n_inc - s_inc, n_dec - s_dec, n_err - s_err, phase);
        end
        s_inc = n_inc; s_dec = n_dec; s_err = n_err;
        @(negedge clk);
        qa = 1'b1;
        repeat (FILT_LEN) @(negedge clk);
        qa = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ((n_inc - s_inc) !== 1 || (n_dec - s_dec) !== 0 || phase !== 2'b11) begin
            errors++; $display("FAIL glitch_accept: got inc=%0d dec=%0d phase=%b expected 1/0/11",
                               n_inc - s_inc, n_dec - s_dec, phase);
        end
        repeat (10) @(negedge clk);
        checks++;
        if ((n_inc - s_inc) !== 1 || (n_dec - s_dec) !== 1 || (n_err - s_err) !== 0 || phase !== 2'b01) begin
            errors++; $display("FAIL glitch_return: got inc=%0d dec=%0d err=%0d phase=%b expected 1/1/0/01",
                               n_inc - s_inc, n_dec - s_dec, n_err - s_err, phase);
        end
    endtask

    task automatic test_error;
        int s_inc, s_dec, s_err;
        step(1'b0, 1'b0, 10);
        s_inc = n_inc; s_dec = n_dec; s_err = n_err;
        step(1'b1, 1'b1, 10);
        checks++;
        if ((n_err - s_err) !== 1 || err_cnt !== 8'd1 || (n_inc - s_inc) !== 0 || (n_dec - s_dec) !== 0) begin
            errors++; $display("FAIL err_single: got err=%0d err_cnt=%0d inc=%0d dec=%0d expected 1/1/0/0",
                               n_err - s_err, err_cnt, n_inc - s_inc, n_dec - s_dec);
        end
        step(1'b1, 1'b0, 10);
        checks++;
        if ((n_inc - s_inc) !== 1 || (n_err - s_err) !== 1 || phase !== 2'b10) begin
            errors++; $display("FAIL err_resync: got inc=%0d err=%0d phase=%b expected 1/1/10",
                               n_inc - s_inc, n_err - s_err, phase);
        end
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) step(1'b0, 1'b1, 8);
            else            step(1'b1, 1'b0, 8);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (err_cnt !== 8'd255 || err_cnt_v !== 8'd255) begin
            errors++; $display("FAIL err_saturate: got err_cnt=%0d inv=%0d expected 255/255", err_cnt, err_cnt_v);
        end
        checks++;
        if ((n_err - s_err) !== 301 || (n_inc - s_inc) !== 1 || (n_dec - s_dec) !== 0) begin
            errors++; $display("FAIL err_pulses: got err=%0d inc=%0d dec=%0d expected 301/1/0",
                               n_err - s_err, n_inc - s_inc, n_dec - s_dec);
        end
    endtask

    task automatic test_reset_mid;
        int s_inc, s_dec, s_err, s_dec_v;
        @(negedge clk);
        qa = 1'b1; qb = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        checks++;
        if (dec !== 1'b1 || err_cnt !== 8'd255) begin
            errors++; $display("FAIL mid_pre_reset: got dec=%b err_cnt=%0d expected 1/255", dec, err_cnt);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({inc, dec, err} !== 3'b000 || err_cnt !== 8'd0 || phase !== 2'b00) begin
            errors++; $display("FAIL mid_reset_now: got pulses=%b err_cnt=%0d phase=%b expected 000/0/00",
                               {inc, dec, err}, err_cnt, phase);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        s_inc = n_inc; s_dec = n_dec; s_err = n_err;
        repeat (20) @(negedge clk);
        checks++;
        if ((n_inc - s_inc) !== 0 || (n_dec - s_dec) !== 0 || (n_err - s_err) !== 0 || phase !== 2'b11) begin
            errors++; $display("FAIL mid_prime_adopt: got inc=%0d dec=%0d err=%0d phase=%b expected 0/0/0/11",
                               n_inc - s_inc, n_dec - s_dec, n_err - s_err, phase);
        end
        s_inc = n_inc; s_dec_v = n_dec_v;
        step(1'b1, 1'b0, 10);
        checks++;
        if ((n_inc - s_inc) !== 1 || (n_dec_v - s_dec_v) !== 1) begin
            errors++; $display("FAIL dir_inv_step: got inc=%0d inv_dec=%0d expected 1/1", n_inc - s_inc, n_dec_v - s_dec_v);
        end
        s_inc = n_inc; s_dec = n_dec; s_err = n_err;
        en = 1'b0;
        step(1'b0, 1'b0, 10);
        step(1'b1, 1'b1, 10);
        checks++;
        if ((n_inc - s_inc) !== 0 || (n_dec - s_dec) !== 0 || (n_err - s_err) !== 0 ||
            err_cnt !== 8'd0 || phase !== 2'b11) begin
            errors++; $display("FAIL en_low: got inc=%0d dec=%0d err=%0d err_cnt=%0d phase=%b expected 0/0/0/0/11",
                               n_inc - s_inc, n_dec - s_dec, n_err - s_err, err_cnt, phase);
        end
        en = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if ((n_inc - s_inc) !== 0 || (n_dec - s_dec) !== 0 || (n_err - s_err) !== 0) begin
            errors++; $display("FAIL en_no_burst: got inc=%0d dec=%0d err=%0d expected 0/0/0",
                               n_inc - s_inc, n_dec - s_dec, n_err - s_err);
        end
        step(1'b1, 1'b0, 10);
        checks++;
        if ((n_inc - s_inc) !== 1 || (n_dec - s_dec) !== 0 || phase !== 2'b10) begin
            errors++; $display("FAIL en_resume: got inc=%0d dec=%0d phase=%b expected 1/0/10",
                               n_inc - s_inc, n_dec - s_dec, phase);
        end
        checks++;
        if (n_overlap !== 0) begin
            errors++; $display("FAIL inc_dec_overlap: got %0d cycles expected 0", n_overlap);
        end
    endtask

    initial begin
        test_reset;
        test_forward;
        test_reverse;
        test_glitch;
        test_error;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
